// File: rtl/analog_io_bank.sv
// Bank of bidirectional analog channels with per-channel direction/output registers and a
// round-robin scanner that emits the truncated mean of 2^AVG_LOG2 samples per channel.
module analog_io_bank #(
    parameter int unsigned BITS     = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CH_W     = 2,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [CH_W-1:0]          cmd_ch,
    input  logic                     cmd_dir,
    input  logic [BITS-1:0]          cmd_data,
    output logic [CHANNELS-1:0]      dir_o,
    inout  wire  [CHANNELS*BITS-1:0] io_port,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [CH_W-1:0]          res_ch,
    output logic [BITS-1:0]          res_data
);
    localparam int unsigned NumSamples = 1 << AVG_LOG2;
    localparam int unsigned AccW       = BITS + AVG_LOG2;
    localparam int unsigned CntW       = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    typedef enum logic [1:0] {StIdle, StSample, StEmit} state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   scan_ch_q, scan_ch_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              res_valid_q, res_valid_d;
    logic [CH_W-1:0]   res_ch_q, res_ch_d;
    logic [BITS-1:0]   res_data_q, res_data_d;

    logic [CHANNELS-1:0] dir_q;
    logic [BITS-1:0]     out_q   [CHANNELS];
    logic [BITS-1:0]     pin_val [CHANNELS];

    logic            cmd_fire;
    logic            cmd_ch_ok;
    logic            restart;
    logic [BITS-1:0] sample;
    logic [AccW-1:0] sum;

    assign cmd_ready = ~rst;
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign cmd_ch_ok = 32'(cmd_ch) < CHANNELS;

    // Output channels still read back their own driven value through the pin.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_pin
        assign io_port[g*BITS +: BITS] = dir_q[g] ? out_q[g] : {BITS{1'bz}};
        assign pin_val[g]              = io_port[g*BITS +: BITS];
    end

    always_comb begin
        sample = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (32'(scan_ch_q) == i) sample = pin_val[i];
        end
    end

    assign sum = acc_q + AccW'(sample);

    // A direction change on the channel being averaged invalidates the partial sum.
    assign restart = cmd_fire & ~cmd_write & (cmd_ch == scan_ch_q) & (state_q == StSample);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) out_q[i] <= '0;
        end else if (cmd_fire && cmd_ch_ok) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (32'(cmd_ch) == i) begin
                    if (cmd_write) out_q[i] <= cmd_data;
                    else           dir_q[i] <= cmd_dir;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        scan_ch_d   = scan_ch_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;
        case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StSample;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            StSample: begin
                if (restart) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (cnt_q == CntW'(NumSamples - 1)) begin
                    res_data_d  = BITS'(sum >> AVG_LOG2);
                    res_ch_d    = scan_ch_q;
                    res_valid_d = 1'b1;
                    state_d     = StEmit;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StEmit: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    scan_ch_d   = (32'(scan_ch_q) == CHANNELS - 1) ? '0 : scan_ch_q + CH_W'(1);
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = en ? StSample : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            scan_ch_q   <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            scan_ch_q   <= scan_ch_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
        end
    end

    assign dir_o     = dir_q;
    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;
    assign res_data  = res_data_q;

endmodule
